joy2quad_accel: RTL
===================

# joy2quad_accel

Multi-channel digital-joystick-to-quadrature encoder emulator with optional step acceleration. It replaces the fixed single-channel joystick-to-quadrature converter that drives the game core's paddle encoder inputs (Enc_A/Enc_B). Each channel turns held left/right buttons into a Gray-coded A/B stream at a programmable rate. With acceleration enabled, that rate doubles in stages while a direction is held, so digital controls can still do both fine and fast paddle moves.

## Interface
Parameters:
- CHANNELS, 2, number of independent encoder channels (1..8)
- DIV_W, 16, width of the base period input and the per-channel divider counter
- ACCEL_EDGES, 16, steps taken at one acceleration level before moving up a level (≥1)
- ACCEL_MAX, 3, highest acceleration level; the period is shifted right by this much at most (0 disables acceleration structurally)

Ports:
- CLK  in  1  system clock (clk_sys domain)
- RESET  in  1  synchronous, active-high reset
- clkdiv  in  DIV_W  base step period in CLK cycles; 0 = stepping disabled
- accel_en  in  1  1 = acceleration active; 0 = level held at 0
- right  in  CHANNELS  per-channel right request, active high
- left  in  CHANNELS  per-channel left request, active high
- steer  out  2*CHANNELS  quadrature output; bits [2i+1:2i] = {A,B} of channel i
- step  out  CHANNELS  one-cycle pulse per channel, high in the same cycle steer changes
- level  out  2*CHANNELS  current acceleration level of each channel (2 bits/ch, saturates at ACCEL_MAX)

## Operation
- Per channel, the effective direction dir is: right&~left → +1; left&~right → −1; neither or both → idle.
- Phase p (2 bits) maps to steer {A,B}: p0=00, p1=01, p2=11, p3=10. +1 steps p up by 1 mod 4, −1 steps it down by 1 mod 4. Exactly one of A/B toggles per step.
- Effective period: per = clkdiv >> lvl when accel_en=1, else clkdiv. A zero shift result with clkdiv≠0 is clamped to 1. clkdiv=0 means never step.
- Divider cnt (DIV_W bits), each cycle dir≠idle and clkdiv≠0:
  - if cnt ≥ per−1: cnt←0, step fires, p advances;
  - otherwise cnt←cnt+1.
  - per is evaluated every cycle. If per shrinks below cnt+1, the step fires on the next cycle.
- Idle, or clkdiv=0: cnt←0, lvl←0, edge counter←0, p held, no step.
- Direction reversal (dir changes from +1 to −1 or the reverse, with no idle cycle between): cnt←0, lvl←0, edge counter←0. That cycle does not step.
- Acceleration:
  - an edge counter counts steps at the current level;
  - when it reaches ACCEL_EDGES and lvl<ACCEL_MAX: lvl+1, counter←0;
  - at ACCEL_MAX the counter stops;
  - accel_en=0 forces lvl←0 and counter←0 every cycle.
- Channels share only CLK, RESET, clkdiv and accel_en; no other state crosses between channels.

## Timing
- Reset values: steer all 0 (p0), step 0, level 0, internal cnt and edge counters 0.
- Sampling and latency:
  - inputs are sampled at each rising CLK edge; outputs are registered;
  - if dir first goes non-idle for the cycle ending at edge 1, the first step/steer change is visible after edge per (latency per cycles);
  - later steps come every per cycles while dir and per are unchanged.
- The step pulse is exactly 1 cycle wide and aligned with the steer update. With per=1 it is high continuously and steer advances every cycle.
- A level increment takes effect from the cycle after the ACCEL_EDGES-th step. The first step at the new level comes per_new cycles after the last step at the old level.
- RESET mid-run overrides everything: on the next edge all state returns to reset values, and any step in progress is dropped.
- Asynchronous left/right are synchronised upstream; this block assumes them synchronous to CLK.

## Test plan
- Reset, clkdiv=4, accel_en=0, right[0] held 16 cycles → steer[1:0] = 01,11,10,00 after edges 4,8,12,16; step[0] pulses at those edges only; channel 1 stays 00.
- Same setup with left[0] held → steer[1:0] = 10,11,01,00; release for 1 cycle then press again → next step exactly 4 cycles after re-press.
- right[0]=left[0]=1 for 20 cycles → no steps, steer constant. Then drop left → first step 4 cycles later.
- clkdiv=64, accel_en=1, ACCEL_EDGES=16, ACCEL_MAX=3, right held:
  - 16 steps spaced 64, then 16 at 32, then 16 at 16, then spacing 8 indefinitely; level[1:0] reads 0,1,2,3;
  - switch straight to left → level 0, next step 64 cycles later.
- Boundary periods:
  - clkdiv=0 → no steps;
  - clkdiv=1 → steer advances every cycle, step held high;
  - clkdiv=2 at lvl 3 → per clamped to 1;
  - clkdiv changed from 100 to 3 while cnt=50 → step on the next cycle, then every 3.
- Both channels driven in opposite directions at different rates → independent, correct sequences. Assert RESET for 1 cycle mid-sequence → all steer/level/step = 0 on the next edge, and each channel restarts with full per latency.

Source files
------------

// File: rtl/joy2quad_accel.sv
// Joystick-to-quadrature encoder emulator: per-channel Gray-coded A/B stepping
// at a programmable period that optionally halves in stages while a direction is held.
module joy2quad_accel #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_EDGES = 16,
  parameter int ACCEL_MAX   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step,
  output logic [2*CHANNELS-1:0] level
);

  localparam int EC_W = (ACCEL_EDGES > 1) ? $clog2(ACCEL_EDGES) : 1;
  localparam logic [EC_W-1:0]  EC_LAST = EC_W'(ACCEL_EDGES - 1);
  localparam logic [EC_W-1:0]  EC_ONE  = EC_W'(1);
  localparam logic [1:0]       LVL_MAX = 2'(ACCEL_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // Shifted period, clamped to 1 so acceleration can never stall a running divider.
  function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] div,
                                                  input logic [1:0]       lvl,
                                                  input logic             en);
    logic [DIV_W-1:0] sh;
    sh = en ? (div >> lvl) : div;
    if (sh == '0 && div != '0) sh = DIV_ONE;
    return sh;
  endfunction

  // Advance a Gray-coded {A,B} pair by one phase up or down.
  function automatic logic [1:0] gray_step(input logic [1:0] ab, input logic up);
    logic [1:0] p;
    p = {ab[1], ab[1] ^ ab[0]};
    p = up ? p + 2'd1 : p - 2'd1;
    return {p[1], p[1] ^ p[0]};
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       dir;       // {minus, plus}; 00 = idle
    logic [1:0]       dir_prev;
    logic [1:0]       ab;
    logic [1:0]       lvl;
    logic [EC_W-1:0]  ecnt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] per;
    logic             fire;
    logic             stp;

    always_comb begin
      dir  = {left[i] & ~right[i], right[i] & ~left[i]};
      per  = eff_period(clkdiv, lvl, accel_en);
      fire = (cnt >= per - DIV_ONE);
    end

    // Single register stage: divider, phase, level and step pulse all update together.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        dir_prev <= 2'b00;
        ab       <= 2'b00;
        lvl      <= 2'd0;
        ecnt     <= '0;
        cnt      <= '0;
        stp      <= 1'b0;
      end else begin
        dir_prev <= dir;
        stp      <= 1'b0;
        if (dir == 2'b00 || clkdiv == '0) begin
          cnt  <= '0;
          lvl  <= 2'd0;
          ecnt <= '0;
        end else if (dir_prev != 2'b00 && dir_prev != dir) begin
          // Reversal restarts from the base rate and spends this cycle without stepping.
          cnt  <= '0;
          lvl  <= 2'd0;
          ecnt <= '0;
        end else if (fire) begin
          cnt <= '0;
          stp <= 1'b1;
          ab  <= gray_step(ab, dir[0]);
          if (lvl < LVL_MAX) begin
            if (ecnt == EC_LAST) begin
              lvl  <= lvl + 2'd1;
              ecnt <= '0;
            end else begin
              ecnt <= ecnt + EC_ONE;
            end
          end
        end else begin
          cnt <= cnt + DIV_ONE;
        end
        if (!accel_en) begin
          lvl  <= 2'd0;
          ecnt <= '0;
        end
      end
    end

    assign steer[2*i +: 2] = ab;
    assign level[2*i +: 2] = lvl;
    assign step[i]         = stp;
  end

endmodule
